os_xor_slice_misr: RTL and testbench

- Downstream consumer of the 7-bit GF(2) XOR-of-products slice word produced by the OS_XOR2 combinational network.
- Compresses a frame of slice words into a 7-bit signature using a multiple-input signature register (MISR) over GF(2).
- Uses valid/ready handshakes on both sides.
- Sits between the XOR product network and the result/compare logic, so one registered signature per frame replaces per-beat checking.

---
 rtl/os_xor_pkg.sv | 14 +
 rtl/os_misr_step.sv | 13 +
 rtl/os_xor_slice_misr.sv | 93 +++++++++
 tb/tb_os_xor_slice_misr.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/os_xor_pkg.sv
// Shared definitions for the XOR-slice signature path: slice width, default MISR taps, FSM states.
package os_xor_pkg;

  localparam int SLICE_W = 7;
  // x^7 + x^3 + 1, bit i set = tap on x^i
  localparam logic [SLICE_W-1:0] MISR_POLY = 7'h09;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/os_misr_step.sv
// One MISR step over GF(2): shift left, fold the MSB back through the taps, absorb the new word.
module os_misr_step #(
  parameter int             W    = 7,
  parameter logic [W-1:0]   POLY = 7'h09
) (
  input  logic [W-1:0] sig,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig_next
);

  assign sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ din;

endmodule

// File: rtl/os_xor_slice_misr.sv
// Compresses a frame of slice words into one registered MISR signature with beat count.
// Result appears one cycle after the closing beat and is held until out_ready; input stalls meanwhile.
module os_xor_slice_misr
  import os_xor_pkg::*;
#(
  parameter int           W     = SLICE_W,
  parameter int           BEATS = 8,
  parameter logic [W-1:0] POLY  = MISR_POLY,
  parameter int           CW    = $clog2(BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sig,
  output logic [CW-1:0] out_cnt,
  output logic          out_short
);

  state_t        state;
  logic [W-1:0]  sig;
  logic [W-1:0]  sig_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          accept;
  logic          closing;

  os_misr_step #(
    .W    (W),
    .POLY (POLY)
  ) u_step (
    .sig      (sig),
    .din      (in_data),
    .sig_next (sig_nx)
  );

  // Decoded from registered state only, so out_ready never reaches in_ready combinationally.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid & in_ready;
  assign cnt_nx   = cnt + CW'(1);
  assign closing  = in_last | (cnt_nx == CW'(BEATS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sig       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sig   <= '0;
      out_cnt   <= '0;
      out_short <= 1'b0;
    end else if (clr) begin
      // out_sig/out_cnt keep their last values so nothing undefined is ever presented.
      state     <= IDLE;
      sig       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (closing) begin
              out_sig   <= sig_nx;
              out_cnt   <= cnt_nx;
              out_short <= in_last & (cnt_nx < CW'(BEATS));
              out_valid <= 1'b1;
              sig       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              sig   <= sig_nx;
              cnt   <= cnt_nx;
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_os_xor_slice_misr.sv
// Bench for os_xor_slice_misr: directed frame table, corner sequences, then random traffic
// checked every cycle against a polynomial-division reference of the frame signature.
module tb_os_xor_slice_misr;

  localparam int BEATS = 8;
  localparam int CW    = $clog2(BEATS + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [6:0]    out_sig;
  logic [CW-1:0] out_cnt;
  logic          out_short;

  int n_vec = 0;
  int n_err = 0;

  os_xor_slice_misr #(.BEATS(BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sig   (out_sig),
    .out_cnt   (out_cnt),
    .out_short (out_short)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] m_frame[$];
  bit         m_hold  = 1'b0;
  bit         m_valid = 1'b0;
  logic [6:0] m_sig   = '0;
  int         m_cnt   = 0;
  bit         m_short = 1'b0;

  // Signature = (sum d_i * x^(n-1-i)) mod (x^7 + x^3 + 1), computed by long division.
  function automatic logic [6:0] frame_sig();
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < m_frame.size(); i++)
      acc = (acc << 1) ^ {9'b0, m_frame[i]};
    for (int k = 15; k >= 7; k--)
      if (acc[k]) acc = acc ^ (16'h0089 << (k - 7));
    return acc[6:0];
  endfunction

  task automatic model_edge();
    if (clr) begin
      m_frame.delete();
      m_hold  = 1'b0;
      m_valid = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold  = 1'b0;
        m_valid = 1'b0;
      end
    end else if (in_valid) begin
      m_frame.push_back(in_data);
      if (in_last || m_frame.size() == BEATS) begin
        m_sig   = frame_sig();
        m_cnt   = m_frame.size();
        m_short = in_last && (m_frame.size() < BEATS);
        m_valid = 1'b1;
        m_hold  = 1'b1;
        m_frame.delete();
      end
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_hold  = 1'b0;
    m_valid = 1'b0;
    m_sig   = '0;
    m_cnt   = 0;
    m_short = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("in_ready",  int'(in_ready),  int'(!m_hold));
    check("out_valid", int'(out_valid), int'(m_valid));
    check("out_sig",   int'(out_sig),   int'(m_sig));
    check("out_cnt",   int'(out_cnt),   m_cnt);
    check("out_short", int'(out_short), int'(m_short));
  endtask

  // Drive one cycle (called at a negedge), update the model at the edge, compare at the next negedge.
  task automatic step(input bit v, input logic [6:0] d, input bit l, input bit r, input bit c);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    clr       = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  // ---------------- directed frame table ----------------
  typedef struct packed {
    logic [3:0]      n;
    logic [7:0][6:0] d;
    logic            last;
    logic [6:0]      sig;
    logic [3:0]      cnt;
    logic            short_f;
  } vec_t;

  vec_t tbl[5];

  task automatic set_vec(input int i, input int n, input bit last, input logic [6:0] s,
                         input int c, input bit sh);
    tbl[i].n       = 4'(n);
    tbl[i].last    = last;
    tbl[i].sig     = s;
    tbl[i].cnt     = 4'(c);
    tbl[i].short_f = sh;
    tbl[i].d       = '0;
  endtask

  task automatic run_vec(input int i);
    for (int b = 0; b < int'(tbl[i].n); b++)
      step(1'b1, tbl[i].d[b], tbl[i].last && (b == int'(tbl[i].n) - 1), 1'b1, 1'b0);
    check("tbl_valid", int'(out_valid), 1);
    check("tbl_sig",   int'(out_sig),   int'(tbl[i].sig));
    check("tbl_cnt",   int'(out_cnt),   int'(tbl[i].cnt));
    check("tbl_short", int'(out_short), int'(tbl[i].short_f));
    step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
    check("tbl_drain_valid", int'(out_valid), 0);
    check("tbl_drain_ready", int'(in_ready),  1);
  endtask

  logic [6:0] held_sig;

  initial begin
    set_vec(0, 1, 1'b1, 7'h01, 1, 1'b1);
    tbl[0].d[0] = 7'h01;
    set_vec(1, 2, 1'b1, 7'h09, 2, 1'b1);
    tbl[1].d[0] = 7'h40;
    set_vec(2, 8, 1'b0, 7'h00, 8, 1'b0);
    set_vec(3, 8, 1'b1, 7'h09, 8, 1'b0);
    tbl[3].d[0] = 7'h01;
    set_vec(4, 3, 1'b1, 7'h07, 3, 1'b1);
    for (int b = 0; b < 3; b++) tbl[4].d[b] = 7'h01;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_sig",   int'(out_sig),   0);
    check("rst_cnt",   int'(out_cnt),   0);
    check("rst_short", int'(out_short), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(in_ready), 1);

    for (int i = 0; i < 5; i++) run_vec(i);

    // backpressure: frame {11,23} -> 01, then stalled beat 33 while out_ready is low
    step(1'b1, 7'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h23, 1'b1, 1'b0, 1'b0);
    held_sig = out_sig;
    check("bp_sig", int'(held_sig), 7'h01);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 7'h33, 1'b1, 1'b0, 1'b0);
      check("bp_ready_low", int'(in_ready), 0);
      check("bp_stable",    int'(out_sig),  int'(held_sig));
    end
    step(1'b1, 7'h33, 1'b1, 1'b1, 1'b0);
    check("bp_hs_ready", int'(in_ready), 1);
    step(1'b1, 7'h33, 1'b1, 1'b1, 1'b0);
    check("bp_new_sig", int'(out_sig), 7'h33);
    check("bp_new_cnt", int'(out_cnt), 1);
    step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0);

    // clr mid-frame flushes state; the beat presented alongside clr is discarded
    for (int k = 0; k < 3; k++) step(1'b1, 7'h55, 1'b0, 1'b1, 1'b0);
    step(1'b1, 7'h55, 1'b1, 1'b1, 1'b1);
    check("clr_no_out", int'(out_valid), 0);
    step(1'b1, 7'h01, 1'b1, 1'b1, 1'b0);
    check("clr_sig", int'(out_sig), 7'h01);
    check("clr_cnt", int'(out_cnt), 1);
    step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0);

    // asynchronous reset while a result is held
    step(1'b1, 7'h2A, 1'b1, 1'b0, 1'b0);
    check("ar_hold", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", int'(out_valid), 0);
    check("ar_sig",   int'(out_sig),   0);
    check("ar_ready", int'(in_ready),  1);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 7'h7F, 1'b1, 1'b0, 1'b0);
    check("ar_sig7f", int'(out_sig), 7'h7F);
    check("ar_cnt",   int'(out_cnt), 1);
    step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0);

    // random traffic against the reference model
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 7, 7'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
